// File: rtl/xbar_slave_arbiter_if.sv
// rtl/xbar_slave_arbiter_if.sv - master-side and slave-side signal bundle for xbar_slave_arbiter
interface xbar_slave_arbiter_if #(
  parameter int MASTER_NUM = 2,
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32
);
  localparam int GRANT_W = $clog2(MASTER_NUM);

  logic [MASTER_NUM-1:0]        m_req;
  logic [MASTER_NUM-1:0]        m_cmd;
  logic [MASTER_NUM*ADDR_W-1:0] m_addr;
  logic [MASTER_NUM*DATA_W-1:0] m_wdata;
  logic [MASTER_NUM-1:0]        m_ack;
  logic [MASTER_NUM-1:0]        m_resp;
  logic [MASTER_NUM-1:0]        m_err;
  logic [DATA_W-1:0]            m_rdata;
  logic                         s_req;
  logic                         s_cmd;
  logic [ADDR_W-1:0]            s_addr;
  logic [DATA_W-1:0]            s_wdata;
  logic                         s_ack;
  logic                         s_resp;
  logic [DATA_W-1:0]            s_rdata;
  logic [GRANT_W-1:0]           grant_id;
  logic                         busy;

  // slave is the arbiter's view; master is the requesting masters together with the shared slave
  modport slave (
    input  m_req, m_cmd, m_addr, m_wdata, s_ack, s_resp, s_rdata,
    output m_ack, m_resp, m_err, m_rdata, s_req, s_cmd, s_addr, s_wdata, grant_id, busy
  );

  modport master (
    output m_req, m_cmd, m_addr, m_wdata, s_ack, s_resp, s_rdata,
    input  m_ack, m_resp, m_err, m_rdata, s_req, s_cmd, s_addr, s_wdata, grant_id, busy
  );
endinterface

// File: rtl/xbar_slave_arbiter.sv
// rtl/xbar_slave_arbiter.sv - round-robin arbiter sharing one cross-bar slave channel with a watchdog
module xbar_slave_arbiter #(
  parameter int MASTER_NUM = 2,
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int TIMEOUT    = 255
) (
  input logic                  aclk,
  input logic                  aresetn,
  xbar_slave_arbiter_if.slave  bus
);
  localparam int GRANT_W = $clog2(MASTER_NUM);
  localparam int WD_W    = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [WD_W-1:0]    WD_LAST  = WD_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);
  localparam logic [GRANT_W-1:0] LAST_RST = GRANT_W'(MASTER_NUM - 1);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT_RESP, DONE} state_t;

  state_t                  state_q, state_d;
  logic [GRANT_W-1:0]      last_q, last_d, grant_q, grant_d;
  logic                    s_req_q, s_req_d, s_cmd_q, s_cmd_d;
  logic [ADDR_W-1:0]       s_addr_q, s_addr_d;
  logic [DATA_W-1:0]       s_wdata_q, s_wdata_d, rdata_q, rdata_d;
  logic [MASTER_NUM-1:0]   ack_q, ack_d, resp_q, resp_d, err_q, err_d;
  logic [WD_W-1:0]         wd_q, wd_d;
  logic                    busy_q, busy_d;
  logic                    rr_found, wd_hit;
  logic [GRANT_W-1:0]      rr_winner, rr_idx;

  // Search starts one past the previous winner so every requester is served within MASTER_NUM grants
  always_comb begin
    rr_found  = 1'b0;
    rr_winner = '0;
    rr_idx    = '0;
    for (int k = 1; k <= MASTER_NUM; k++) begin
      rr_idx = GRANT_W'((int'(last_q) + k) % MASTER_NUM);
      if (!rr_found && bus.m_req[rr_idx]) begin
        rr_found  = 1'b1;
        rr_winner = rr_idx;
      end
    end
  end

  assign wd_hit = (TIMEOUT != 0) && (wd_q == WD_LAST);

  always_comb begin
    state_d   = state_q;
    last_d    = last_q;
    grant_d   = grant_q;
    s_req_d   = s_req_q;
    s_cmd_d   = s_cmd_q;
    s_addr_d  = s_addr_q;
    s_wdata_d = s_wdata_q;
    ack_d     = '0;
    resp_d    = '0;
    err_d     = '0;
    rdata_d   = rdata_q;
    wd_d      = wd_q;
    case (state_q)
      IDLE: begin
        wd_d = '0;
        if (rr_found) begin
          grant_d   = rr_winner;
          s_cmd_d   = bus.m_cmd[rr_winner];
          s_addr_d  = bus.m_addr[rr_winner*ADDR_W +: ADDR_W];
          s_wdata_d = bus.m_wdata[rr_winner*DATA_W +: DATA_W];
          s_req_d   = 1'b1;
          state_d   = ISSUE;
        end
      end
      ISSUE: begin
        wd_d = wd_q + WD_W'(1);
        // A completion on the watchdog's last cycle takes priority over the abort
        if (bus.s_ack) begin
          s_req_d        = 1'b0;
          ack_d[grant_q] = 1'b1;
          state_d        = s_cmd_q ? DONE : WAIT_RESP;
        end else if (wd_hit) begin
          s_req_d        = 1'b0;
          err_d[grant_q] = 1'b1;
          state_d        = DONE;
        end
      end
      WAIT_RESP: begin
        wd_d = wd_q + WD_W'(1);
        if (bus.s_resp) begin
          resp_d[grant_q] = 1'b1;
          rdata_d         = bus.s_rdata;
          state_d         = DONE;
        end else if (wd_hit) begin
          err_d[grant_q] = 1'b1;
          state_d        = DONE;
        end
      end
      DONE: begin
        last_d    = grant_q;
        s_cmd_d   = 1'b0;
        s_addr_d  = '0;
        s_wdata_d = '0;
        state_d   = IDLE;
      end
      default: state_d = IDLE;
    endcase
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      state_q   <= IDLE;
      last_q    <= LAST_RST;
      grant_q   <= '0;
      s_req_q   <= 1'b0;
      s_cmd_q   <= 1'b0;
      s_addr_q  <= '0;
      s_wdata_q <= '0;
      ack_q     <= '0;
      resp_q    <= '0;
      err_q     <= '0;
      rdata_q   <= '0;
      wd_q      <= '0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      last_q    <= last_d;
      grant_q   <= grant_d;
      s_req_q   <= s_req_d;
      s_cmd_q   <= s_cmd_d;
      s_addr_q  <= s_addr_d;
      s_wdata_q <= s_wdata_d;
      ack_q     <= ack_d;
      resp_q    <= resp_d;
      err_q     <= err_d;
      rdata_q   <= rdata_d;
      wd_q      <= wd_d;
      busy_q    <= busy_d;
    end
  end

  assign bus.s_req    = s_req_q;
  assign bus.s_cmd    = s_cmd_q;
  assign bus.s_addr   = s_addr_q;
  assign bus.s_wdata  = s_wdata_q;
  assign bus.m_ack    = ack_q;
  assign bus.m_resp   = resp_q;
  assign bus.m_err    = err_q;
  assign bus.m_rdata  = rdata_q;
  assign bus.grant_id = grant_q;
  assign bus.busy     = busy_q;
endmodule

// File: tb/tb_xbar_slave_arbiter.sv
// tb/tb_xbar_slave_arbiter.sv - table and scoreboard bench for xbar_slave_arbiter
module tb_xbar_slave_arbiter;
  localparam int MN = 2;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int TO = 8;

  logic aclk = 1'b0;
  logic aresetn;
  always #5 aclk = ~aclk;

  xbar_slave_arbiter_if #(.MASTER_NUM(MN), .ADDR_W(AW), .DATA_W(DW)) bus ();

  xbar_slave_arbiter #(.MASTER_NUM(MN), .ADDR_W(AW), .DATA_W(DW), .TIMEOUT(TO)) dut (
    .aclk    (aclk),
    .aresetn (aresetn),
    .bus     (bus)
  );

  typedef struct {
    int          m;
    logic        cmd;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    int          ad;
    int          rd;
    logic [0:0]  exp_grant;
    logic        exp_acked;
    logic        exp_err;
  } txn_t;

  typedef struct {
    int            cyc;
    logic [MN-1:0] ack;
    logic [MN-1:0] resp;
    logic [MN-1:0] err;
    logic [DW-1:0] rdata;
  } pulse_t;

  typedef struct {
    logic [0:0]    grant;
    logic          cmd;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
  } issue_t;

  pulse_t        pq[$];
  issue_t        iq[$];
  txn_t          tbl[10];
  int            n_cmp = 0;
  int            n_bad = 0;
  int            cyc = 0;
  logic          s_req_prev = 1'b0;
  logic [DW-1:0] last_rdata = '0;

  always @(posedge aclk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s at cycle %0d: got %0h expected %0h", name, cyc, act, exp);
    end
  endtask

  // Scoreboard: issue fields on every s_req rise, pulses on the exact cycle they were scheduled
  always @(negedge aclk) begin
    if (bus.s_req === 1'b1 && s_req_prev !== 1'b1) begin
      if (iq.size() == 0) chk("issue_unexpected", bus.s_req, 1'b0);
      else begin
        chk("issue_fields", {bus.grant_id, bus.s_cmd, bus.s_addr, bus.s_wdata},
            {iq[0].grant, iq[0].cmd, iq[0].addr, iq[0].wdata});
        void'(iq.pop_front());
      end
    end
    if (pq.size() != 0 && pq[0].cyc == cyc) begin
      chk("pulse", {bus.s_req, bus.m_ack, bus.m_resp, bus.m_err},
          {1'b0, pq[0].ack, pq[0].resp, pq[0].err});
      if (pq[0].resp != '0) chk("rdata", bus.m_rdata, pq[0].rdata);
      void'(pq.pop_front());
    end else if ((bus.m_ack | bus.m_resp | bus.m_err) != '0) begin
      chk("pulse_unexpected", {bus.m_ack, bus.m_resp, bus.m_err}, '0);
    end
    s_req_prev <= bus.s_req;
  end

  task automatic wait_sreq(output bit seen);
    seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge aclk);
      seen = (bus.s_req === 1'b1);
    end
    if (!seen) chk("grant_timeout", bus.s_req, 1'b1);
  endtask

  task automatic run_txn(input txn_t t);
    int n;
    int fin;
    bit seen;
    iq.push_back('{grant: t.exp_grant, cmd: t.cmd, addr: t.addr, wdata: t.wdata});
    bus.m_req[t.m]             = 1'b1;
    bus.m_cmd[t.m]             = t.cmd;
    bus.m_addr[t.m*AW +: AW]   = t.addr;
    bus.m_wdata[t.m*DW +: DW]  = t.wdata;
    wait_sreq(seen);
    bus.m_req[t.m] = 1'b0;
    if (!seen) return;
    n = cyc;
    if (t.exp_acked)
      pq.push_back('{cyc: n + t.ad, ack: MN'(1) << t.m, resp: '0, err: '0, rdata: '0});
    if (!t.cmd && t.exp_acked && !t.exp_err)
      pq.push_back('{cyc: n + t.ad + t.rd, ack: '0, resp: MN'(1) << t.m, err: '0, rdata: t.rdata});
    if (t.exp_err)
      pq.push_back('{cyc: n + TO, ack: '0, resp: '0, err: MN'(1) << t.m, rdata: '0});
    fin = t.exp_err ? n + TO : (t.cmd ? n + t.ad : n + t.ad + t.rd);
    if (t.exp_acked) begin
      while (cyc < n + t.ad - 1) begin @(posedge aclk); #1; end
      bus.s_ack = 1'b1;
      @(posedge aclk); #1;
      bus.s_ack = 1'b0;
      if (!t.cmd && !t.exp_err) begin
        while (cyc < n + t.ad + t.rd - 1) begin @(posedge aclk); #1; end
        bus.s_resp  = 1'b1;
        bus.s_rdata = t.rdata;
        @(posedge aclk); #1;
        bus.s_resp  = 1'b0;
        bus.s_rdata = $urandom();
        last_rdata  = t.rdata;
      end
    end
    while (cyc < fin + 1) begin @(posedge aclk); #1; end
    chk("idle_busy", bus.busy, 1'b0);
    chk("rdata_hold", bus.m_rdata, last_rdata);
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_ctrl"}, {bus.s_req, bus.m_ack, bus.m_resp, bus.m_err, bus.busy, bus.grant_id}, '0);
    chk({tag, "_data"}, {bus.s_cmd, bus.s_addr, bus.s_wdata, bus.m_rdata}, '0);
  endtask

  initial begin
    int n0;
    bit seen;
    aresetn     = 1'b0;
    bus.m_req   = '0;
    bus.m_cmd   = '0;
    bus.m_addr  = '0;
    bus.m_wdata = '0;
    bus.s_ack   = 1'b0;
    bus.s_resp  = 1'b0;
    bus.s_rdata = '0;

    tbl[0] = '{m: 0, cmd: 1, addr: 'h10, wdata: 'hA5,       rdata: 0,          ad: 2, rd: 0, exp_grant: 0, exp_acked: 1, exp_err: 0};
    tbl[1] = '{m: 1, cmd: 0, addr: 'h20, wdata: 'h0,        rdata: 'hDEADBEEF, ad: 2, rd: 3, exp_grant: 1, exp_acked: 1, exp_err: 0};
    tbl[2] = '{m: 0, cmd: 0, addr: 'h30, wdata: 'h3,        rdata: 'h12345678, ad: 1, rd: 1, exp_grant: 0, exp_acked: 1, exp_err: 0};
    tbl[3] = '{m: 1, cmd: 1, addr: 'h44, wdata: 'h5555AAAA, rdata: 0,          ad: 1, rd: 0, exp_grant: 1, exp_acked: 1, exp_err: 0};
    tbl[4] = '{m: 1, cmd: 1, addr: 'h48, wdata: 'h0F0F0F0F, rdata: 0,          ad: 3, rd: 0, exp_grant: 1, exp_acked: 1, exp_err: 0};
    tbl[5] = '{m: 0, cmd: 0, addr: 'h50, wdata: 'h5,        rdata: 0,          ad: 0, rd: 0, exp_grant: 0, exp_acked: 0, exp_err: 1};
    tbl[6] = '{m: 1, cmd: 1, addr: 'h60, wdata: 'h66,       rdata: 0,          ad: 8, rd: 0, exp_grant: 1, exp_acked: 1, exp_err: 0};
    tbl[7] = '{m: 0, cmd: 0, addr: 'h70, wdata: 'h7,        rdata: 0,          ad: 2, rd: 0, exp_grant: 0, exp_acked: 1, exp_err: 1};
    tbl[8] = '{m: 1, cmd: 0, addr: 'h80, wdata: 'h8,        rdata: 'hCAFEF00D, ad: 2, rd: 6, exp_grant: 1, exp_acked: 1, exp_err: 0};
    tbl[9] = '{m: 0, cmd: 1, addr: 'h90, wdata: 'h99,       rdata: 0,          ad: 7, rd: 0, exp_grant: 0, exp_acked: 1, exp_err: 0};

    repeat (3) @(posedge aclk);
    @(negedge aclk);
    chk_reset_vals("reset");
    @(posedge aclk); #1;
    aresetn = 1'b1;

    for (int i = 0; i < 10; i++) run_txn(tbl[i]);

    // Reset while a read waits for its response: no completion may follow
    iq.push_back('{grant: 1'b1, cmd: 1'b0, addr: 'hA0, wdata: 'h0});
    bus.m_cmd[1]        = 1'b0;
    bus.m_addr[AW +: AW]  = 'hA0;
    bus.m_wdata[DW +: DW] = '0;
    bus.m_req[1]        = 1'b1;
    wait_sreq(seen);
    bus.m_req = '0;
    n0 = cyc;
    pq.push_back('{cyc: n0 + 1, ack: 2'b10, resp: '0, err: '0, rdata: '0});
    bus.s_ack = 1'b1;
    @(posedge aclk); #1;
    bus.s_ack = 1'b0;
    aresetn   = 1'b0;
    @(posedge aclk); #1;
    aresetn     = 1'b1;
    bus.s_resp  = 1'b1;
    bus.s_rdata = 'h0BAD0BAD;
    @(negedge aclk);
    chk_reset_vals("mid_reset");
    @(posedge aclk); #1;
    bus.s_resp = 1'b0;
    last_rdata = '0;
    repeat (10) @(posedge aclk);
    #1;
    chk("post_reset_rdata", bus.m_rdata, last_rdata);
    chk("post_reset_busy", bus.busy, 1'b0);

    // Both masters request writes continuously: grants must alternate starting at master 0
    for (int k = 0; k < 6; k++)
      iq.push_back('{grant: 1'(k % 2), cmd: 1'b1, addr: 32'h100 + 32'(4 * (k % 2)), wdata: 32'hB0 + 32'(k % 2)});
    bus.m_cmd   = 2'b11;
    bus.m_addr  = {32'h104, 32'h100};
    bus.m_wdata = {32'hB1, 32'hB0};
    bus.m_req   = 2'b11;
    for (int k = 0; k < 6; k++) begin
      wait_sreq(seen);
      if (seen) begin
        pq.push_back('{cyc: cyc + 1, ack: (k % 2 == 0) ? 2'b01 : 2'b10, resp: '0, err: '0, rdata: '0});
        bus.s_ack = 1'b1;
        @(posedge aclk); #1;
        bus.s_ack = 1'b0;
        if (k == 5) bus.m_req = '0;
      end
    end
    bus.m_req = '0;
    repeat (5) @(posedge aclk);
    #1;
    chk("final_busy", bus.busy, 1'b0);
    chk("issue_queue_drained", iq.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
